// File: rtl/lmc1992_rx.sv
// -----------------------------------------------------------------------------
// lmc1992_rx
//
// Receiver and audio path for an LMC1992-style tone/volume controller.
// A three-wire microwire port (clock, data, frame enable), all synchronous to
// clk32, delivers 11-bit command frames: a 2-bit address (must be 2'b10), a
// 3-bit function code and 6 data bits, sent MSB first. Each accepted frame
// updates one control register. The master and left/right volume registers
// set a per-channel attenuation that scales the unsigned 8-bit DMA samples
// into signed 16-bit output samples.
//
// Configuration macro: LMC_TONE_EN
//   defined   - bass and treble are stored and decoded from their frames
//   undefined - bass/treble frames are ignored and both read as constant 6
//
// Ports
//   clk32        in   system clock (32 MHz)
//   resb         in   asynchronous active-low reset
//   mw_clk       in   microwire bit clock (sampled on its rising edge)
//   mw_data      in   microwire serial data
//   mw_en        in   microwire frame enable (frame ends on its falling edge)
//   audio_left   in   [7:0]  unsigned left sample, 128 = silence
//   audio_right  in   [7:0]  unsigned right sample, 128 = silence
//   out_left     out  [15:0] signed attenuated left sample (2-cycle latency)
//   out_right    out  [15:0] signed attenuated right sample (2-cycle latency)
//   master       out  [5:0]  master volume, 0..40
//   vol_left     out  [4:0]  left volume, 0..20
//   vol_right    out  [4:0]  right volume, 0..20
//   bass         out  [3:0]  bass setting, 0..12
//   treble       out  [3:0]  treble setting, 0..12
//   mixer        out  [1:0]  mixer select
// -----------------------------------------------------------------------------
module lmc1992_rx (
    input  logic        clk32,
    input  logic        resb,
    input  logic        mw_clk,
    input  logic        mw_data,
    input  logic        mw_en,
    input  logic [7:0]  audio_left,
    input  logic [7:0]  audio_right,
    output logic [15:0] out_left,
    output logic [15:0] out_right,
    output logic [5:0]  master,
    output logic [4:0]  vol_left,
    output logic [4:0]  vol_right,
    output logic [3:0]  bass,
    output logic [3:0]  treble,
    output logic [1:0]  mixer
);

    typedef enum logic [2:0] {
        FN_MIXER  = 3'b000,
        FN_BASS   = 3'b001,
        FN_TREBLE = 3'b010,
        FN_MASTER = 3'b011,
        FN_VOL_R  = 3'b100,
        FN_VOL_L  = 3'b101
    } fn_e;

    localparam logic [3:0] FRAME_BITS = 4'd11;

    // -------------------------------------------------------------------------
    // Microwire edge detection
    // -------------------------------------------------------------------------
    logic mw_clk_d;
    logic mw_en_d;
    logic rise;
    logic fall;
    logic start;
    logic shift_en;

    assign rise  = mw_clk & ~mw_clk_d;
    assign fall  = mw_en_d & ~mw_en;
    assign start = mw_en & ~mw_en_d;
    // A bit clocked in on the very cycle the enable drops still belongs to
    // the frame, so the delayed enable keeps the shifter open for that cycle.
    assign shift_en = rise & (mw_en | mw_en_d);

    // -------------------------------------------------------------------------
    // Shift register and bit counter
    // -------------------------------------------------------------------------
    logic [10:0] shift_q;
    logic [3:0]  cnt_q;
    logic [10:0] shift_nxt;
    logic [3:0]  cnt_nxt;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        shift_nxt = shift_q;
        cnt_nxt   = start ? 4'd0 : cnt_q;
        if (shift_en) begin
            // Older bits fall off the top, so a long frame keeps its last 11.
            shift_nxt = {shift_q[9:0], mw_data};
            if (cnt_nxt != FRAME_BITS) begin
                cnt_nxt = cnt_nxt + 4'd1;
            end
        end
    end

    // Decode looks at the next-state values so a bit arriving together with
    // the frame end is included in the command.
    logic       frame_ok;
    logic [2:0] fn_code;
    logic [5:0] fn_data;

    assign frame_ok = fall && (cnt_nxt == FRAME_BITS) && (shift_nxt[10:9] == 2'b10);
    assign fn_code  = shift_nxt[8:6];
    assign fn_data  = shift_nxt[5:0];

    function automatic logic [3:0] clamp12(input logic [3:0] v);
        return (v > 4'd12) ? 4'd12 : v;
    endfunction

    function automatic logic [4:0] clamp20(input logic [4:0] v);
        return (v > 5'd20) ? 5'd20 : v;
    endfunction

    function automatic logic [5:0] clamp40(input logic [5:0] v);
        return (v > 6'd40) ? 6'd40 : v;
    endfunction

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            mw_clk_d  <= 1'b0;
            mw_en_d   <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            master    <= 6'd40;
            vol_left  <= 5'd20;
            vol_right <= 5'd20;
            mixer     <= 2'b01;
        end else begin
            mw_clk_d <= mw_clk;
            mw_en_d  <= mw_en;
            shift_q  <= shift_nxt;
            cnt_q    <= cnt_nxt;
            if (frame_ok) begin
                case (fn_code)
                    FN_MIXER:  mixer     <= fn_data[1:0];
                    FN_MASTER: master    <= clamp40(fn_data);
                    FN_VOL_R:  vol_right <= clamp20(fn_data[4:0]);
                    FN_VOL_L:  vol_left  <= clamp20(fn_data[4:0]);
                    default:   ;
                endcase
            end
        end
    end

`ifdef LMC_TONE_EN
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            bass   <= 4'd6;
            treble <= 4'd6;
        end else if (frame_ok) begin
            if (fn_code == FN_BASS) begin
                bass <= clamp12(fn_data[3:0]);
            end
            if (fn_code == FN_TREBLE) begin
                treble <= clamp12(fn_data[3:0]);
            end
        end
    end
`else
    assign bass   = 4'd6;
    assign treble = 4'd6;
`endif

    // -------------------------------------------------------------------------
    // Attenuation and gain
    // -------------------------------------------------------------------------
    // att = (40 - master) + (20 - vol); register clamps keep this in 0..60.
    logic [6:0] att_left;
    logic [6:0] att_right;

    assign att_left  = 7'd60 - {1'b0, master} - {2'b00, vol_left};
    assign att_right = 7'd60 - {1'b0, master} - {2'b00, vol_right};

    // gain(att) = round(255 * 10^(-att/10)); anything at or past 40 is mute.
    function automatic logic [7:0] gain_lut(input logic [6:0] att);
        logic [7:0] g;
        case (att)
            7'd0:  g = 8'd255;
            7'd1:  g = 8'd203;
            7'd2:  g = 8'd161;
            7'd3:  g = 8'd128;
            7'd4:  g = 8'd102;
            7'd5:  g = 8'd81;
            7'd6:  g = 8'd64;
            7'd7:  g = 8'd51;
            7'd8:  g = 8'd40;
            7'd9:  g = 8'd32;
            7'd10: g = 8'd26;
            7'd11: g = 8'd20;
            7'd12: g = 8'd16;
            7'd13: g = 8'd13;
            7'd14: g = 8'd10;
            7'd15: g = 8'd8;
            7'd16: g = 8'd6;
            7'd17: g = 8'd5;
            7'd18: g = 8'd4;
            7'd19: g = 8'd3;
            7'd20: g = 8'd3;
            7'd21: g = 8'd2;
            7'd22: g = 8'd2;
            7'd23: g = 8'd1;
            7'd24: g = 8'd1;
            7'd25: g = 8'd1;
            7'd26: g = 8'd1;
            7'd27: g = 8'd1;
            default: g = 8'd0;
        endcase
        return g;
    endfunction

    // -------------------------------------------------------------------------
    // Two-stage audio pipeline
    // -------------------------------------------------------------------------
    // Flipping the MSB turns offset-binary (128 = 0) into two's complement.
    logic signed [7:0]  samp_l_q;
    logic signed [7:0]  samp_r_q;
    logic [7:0]         gain_l_q;
    logic [7:0]         gain_r_q;
    logic signed [16:0] prod_l;
    logic signed [16:0] prod_r;

    assign prod_l = samp_l_q * $signed({1'b0, gain_l_q});
    assign prod_r = samp_r_q * $signed({1'b0, gain_r_q});

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            samp_l_q  <= '0;
            samp_r_q  <= '0;
            gain_l_q  <= '0;
            gain_r_q  <= '0;
            out_left  <= '0;
            out_right <= '0;
        end else begin
            samp_l_q  <= $signed(audio_left ^ 8'h80);
            samp_r_q  <= $signed(audio_right ^ 8'h80);
            gain_l_q  <= gain_lut(att_left);
            gain_r_q  <= gain_lut(att_right);
            // |product| <= 32640, so the low 16 bits hold it exactly.
            out_left  <= prod_l[15:0];
            out_right <= prod_r[15:0];
        end
    end

endmodule

// File: tb/tb_lmc1992_rx.sv
`timescale 1ns / 1ps
module tb_lmc1992_rx;

    logic        clk32 = 1'b0;
    logic        resb;
    logic        mw_clk;
    logic        mw_data;
    logic        mw_en;
    logic [7:0]  audio_left;
    logic [7:0]  audio_right;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic [5:0]  master;
    logic [4:0]  vol_left;
    logic [4:0]  vol_right;
    logic [3:0]  bass;
    logic [3:0]  treble;
    logic [1:0]  mixer;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, derived from the frame rules only.
    int m_master, m_vol_l, m_vol_r, m_bass, m_treble, m_mixer;

    always #15.625 clk32 = ~clk32;

    lmc1992_rx dut (
        .clk32      (clk32),
        .resb       (resb),
        .mw_clk     (mw_clk),
        .mw_data    (mw_data),
        .mw_en      (mw_en),
        .audio_left (audio_left),
        .audio_right(audio_right),
        .out_left   (out_left),
        .out_right  (out_right),
        .master     (master),
        .vol_left   (vol_left),
        .vol_right  (vol_right),
        .bass       (bass),
        .treble     (treble),
        .mixer      (mixer)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Gain straight from the formula; the tiny bias resolves att=10 (25.5) upward.
    function automatic int ref_gain(input int att);
        if (att >= 40) return 0;
        return int'($floor(255.0 * $pow(10.0, -att / 10.0) + 0.5 + 1.0e-9));
    endfunction

    function automatic int ref_out(input int audio, input int vol);
        int att;
        att = (40 - m_master) + (20 - vol);
        return (audio - 128) * ref_gain(att);
    endfunction

    task automatic model_reset();
        m_master = 40; m_vol_l = 20; m_vol_r = 20;
        m_bass = 6; m_treble = 6; m_mixer = 1;
    endtask

    // Frame as a whole: only the last 11 bits matter, and only with address 10.
    task automatic model_frame(input logic [15:0] bits, input int n);
        int fn, d;
        if (n < 11) return;
        if (bits[10:9] != 2'b10) return;
        fn = int'(bits[8:6]);
        d  = int'(bits[5:0]);
        case (fn)
            0: m_mixer = d % 4;
`ifdef LMC_TONE_EN
            1: m_bass = imin(d % 16, 12);
            2: m_treble = imin(d % 16, 12);
`endif
            3: m_master = imin(d, 40);
            4: m_vol_r = imin(d % 32, 20);
            5: m_vol_l = imin(d % 32, 20);
            default: ;
        endcase
    endtask

    // Sends bits[n-1:0] MSB first; 'coincide' makes the last rising clock
    // coincide with the enable dropping.
    task automatic send_frame(input logic [15:0] bits, input int n, input bit coincide);
        @(negedge clk32);
        mw_en = 1'b1; mw_clk = 1'b0;
        repeat (2) @(negedge clk32);
        for (int i = n - 1; i >= 0; i--) begin
            mw_data = bits[i];
            mw_clk  = 1'b0;
            @(negedge clk32);
            if (i == 0 && coincide) begin
                mw_clk = 1'b1; mw_en = 1'b0;
                @(negedge clk32);
            end else begin
                mw_clk = 1'b1;
                repeat (2) @(negedge clk32);
            end
        end
        mw_clk = 1'b0; mw_en = 1'b0;
        repeat (3) @(negedge clk32);
        model_frame(bits, n);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".master"}, int'(master), m_master);
        check({tag, ".vol_left"}, int'(vol_left), m_vol_l);
        check({tag, ".vol_right"}, int'(vol_right), m_vol_r);
        check({tag, ".bass"}, int'(bass), m_bass);
        check({tag, ".treble"}, int'(treble), m_treble);
        check({tag, ".mixer"}, int'(mixer), m_mixer);
    endtask

    task automatic check_audio(input string tag, input int al, input int ar);
        @(negedge clk32);
        audio_left = al[7:0]; audio_right = ar[7:0];
        repeat (2) @(posedge clk32);
        @(negedge clk32);
        check({tag, ".out_left"}, int'($signed(out_left)), ref_out(al, m_vol_l));
        check({tag, ".out_right"}, int'($signed(out_right)), ref_out(ar, m_vol_r));
    endtask

    task automatic do_reset();
        resb = 1'b0;
        repeat (3) @(negedge clk32);
        resb = 1'b1;
        model_reset();
        @(negedge clk32);
    endtask

    initial begin
        logic [15:0] fr;
        int          n;
        mw_clk = 0; mw_data = 0; mw_en = 0;
        audio_left = 8'h80; audio_right = 8'h80;
        resb = 1'b0;
        model_reset();
        #1;
        check("reset.out_left", int'(out_left), 0);
        check("reset.out_right", int'(out_right), 0);
        repeat (2) @(negedge clk32);
        check_regs("reset");
        resb = 1'b1;
        @(negedge clk32);

        // Full-scale sample at unity gain.
        check_audio("fullscale", 8'hFF, 8'h00);
        check("fullscale.abs", int'($signed(out_left)), 32385);

        // master = 20 gives att 20.
        send_frame(16'b10_011_010100, 11, 0);
        check_regs("master20");
        check_audio("master20", 8'h90, 8'h70);
        check("master20.abs", int'($signed(out_left)), 48);

        // Clamping.
        send_frame(16'b10_100_111111, 11, 0);
        check_regs("volr_clamp");
        send_frame(16'b10_011_101000, 11, 0);
        check_regs("master40");

        // Rejected frames: short, and wrong address.
        send_frame(16'b10_101_00011, 10, 0);
        check_regs("short");
        send_frame(16'b01_101_000011, 11, 0);
        check_regs("badaddr");

        // Long frame keeps the last 11 bits.
        send_frame(16'b011_10_101_001110, 13, 0);
        check_regs("long13");
        check("long13.vol_left", int'(vol_left), 14);
        check_audio("long13", 8'hC0, 8'h40);

        // Bit and frame end on the same cycle.
        send_frame(16'b10_000_000011, 11, 1);
        check_regs("coincide");

        // Bass frame (kept or ignored by build).
        send_frame(16'b10_001_000011, 11, 0);
        check_regs("bass");

        // Reset mid-frame: the leftover bits must not form a command.
        @(negedge clk32);
        mw_en = 1'b1;
        fr = 16'b10_011_010100;
        for (int i = 10; i >= 5; i--) begin
            mw_data = fr[i]; mw_clk = 0; @(negedge clk32);
            mw_clk = 1; repeat (2) @(negedge clk32);
        end
        mw_clk = 0;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            mw_data = fr[i]; mw_clk = 0; @(negedge clk32);
            mw_clk = 1; repeat (2) @(negedge clk32);
        end
        mw_clk = 0; mw_en = 0;
        repeat (3) @(negedge clk32);
        check_regs("midreset");

        // Randomized frames and samples.
        for (int k = 0; k < 60; k++) begin
            int r;
            fr = 16'($urandom);
            r = int'($urandom_range(0, 9));
            n = (r == 0) ? 10 : (r == 1) ? 12 : (r == 2) ? 13 : 11;
            if ($urandom_range(0, 7) != 0) fr[10:9] = 2'b10;
            send_frame(fr, n, bit'($urandom_range(0, 1)));
            check_regs($sformatf("rnd%0d", k));
            check_audio($sformatf("rnd%0d", k),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #2ms;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
